// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds one fetched instruction for decode, tracks the PC,
// and handles stall, redirect, halt and misaligned-target cases.
module fetch_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_halt,
  output logic        o_imem_ren,
  output logic [31:0] o_imem_raddr,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_imem_rvalid,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  output logic [31:0] o_nxt_pc,
  output logic        o_valid,
  output logic [31:0] o_fetch_cnt
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {RUN, HALTED} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        valid_q, valid_d;
  logic [31:0] cnt_q, cnt_d;
  logic        capture;

  // A misaligned PC never requests, so the stage parks until redirect/halt/reset.
  assign o_imem_ren = (state_q == RUN) && (pc_q[1:0] == 2'b00) && !(valid_q && i_stall)
                      && !i_redirect && !i_halt;
  assign capture    = o_imem_ren && i_imem_rvalid;

  assign o_imem_raddr = pc_q;
  assign o_nxt_pc     = pc_q;
  assign o_inst       = inst_q;
  assign o_inst_pc    = inst_pc_q;
  assign o_valid      = valid_q;
  assign o_fetch_cnt  = cnt_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= RUN;
      pc_q      <= RESET_ADDR;
      inst_q    <= NOP;
      inst_pc_q <= RESET_ADDR;
      valid_q   <= 1'b0;
      cnt_q     <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    valid_d   = valid_q;
    cnt_d     = cnt_q;
    if (state_q == HALTED) begin
      valid_d = 1'b0;
    end else if (i_halt) begin
      state_d = HALTED;
      valid_d = 1'b0;
    end else if (i_redirect) begin
      pc_d    = i_redirect_pc;
      valid_d = 1'b0;
    end else if (valid_q && i_stall) begin
      valid_d = 1'b1;
    end else if (capture) begin
      inst_d    = i_imem_rdata;
      inst_pc_d = pc_q;
      valid_d   = 1'b1;
      pc_d      = pc_q + 32'd4;
      cnt_d     = cnt_q + 32'd1;
    end else begin
      valid_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with fixed expectations, then a
// randomized run checked cycle by cycle against a behavioural fetch model.
module tb_fetch_unit;

  logic        i_clk = 1'b0;
  logic        i_rst, i_stall, i_redirect, i_halt, i_imem_rvalid;
  logic [31:0] i_redirect_pc, i_imem_rdata;
  logic        o_imem_ren, o_valid;
  logic [31:0] o_imem_raddr, o_inst, o_inst_pc, o_nxt_pc, o_fetch_cnt;

  int n_pass = 0;
  int n_total = 0;

  // behavioural model state
  logic [31:0] m_pc, m_inst, m_inst_pc, m_cnt;
  logic        m_valid, m_halted, m_ren;

  fetch_unit #(.RESET_ADDR(32'h0000_0000)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_stall(i_stall), .i_redirect(i_redirect),
    .i_redirect_pc(i_redirect_pc), .i_halt(i_halt), .o_imem_ren(o_imem_ren),
    .o_imem_raddr(o_imem_raddr), .i_imem_rdata(i_imem_rdata), .i_imem_rvalid(i_imem_rvalid),
    .o_inst(o_inst), .o_inst_pc(o_inst_pc), .o_nxt_pc(o_nxt_pc), .o_valid(o_valid),
    .o_fetch_cnt(o_fetch_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic drv(input logic stall, input logic redir, input logic [31:0] rpc,
                     input logic halt, input logic rvalid, input logic [31:0] rdata);
    i_stall = stall; i_redirect = redir; i_redirect_pc = rpc;
    i_halt = halt; i_imem_rvalid = rvalid; i_imem_rdata = rdata;
    #1;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    #2 i_rst = 1'b1;
    #3 i_rst = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    n_total++; if (o_nxt_pc !== 32'h0) $display("FAIL rst_pc got %h want 0", o_nxt_pc); else n_pass++;
    n_total++; if (o_inst !== 32'h13) $display("FAIL rst_inst got %h want 13", o_inst); else n_pass++;
    n_total++; if (o_inst_pc !== 32'h0) $display("FAIL rst_inst_pc got %h want 0", o_inst_pc); else n_pass++;
    n_total++; if (o_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", o_valid); else n_pass++;
    n_total++; if (o_fetch_cnt !== 32'h0) $display("FAIL rst_cnt got %0d want 0", o_fetch_cnt); else n_pass++;
    tick();
    i_rst = 1'b0;
    #1;
    n_total++; if (o_imem_ren !== 1'b1 || o_imem_raddr !== 32'h0)
      $display("FAIL rst_ren got ren=%b addr=%h want ren=1 addr=0", o_imem_ren, o_imem_raddr); else n_pass++;
  endtask

  task automatic test_zero_wait();
    for (int k = 0; k < 6; k++) begin
      drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hA000_0000 + k);
      n_total++; if (o_imem_ren !== 1'b1 || o_imem_raddr !== 32'(4 * k))
        $display("FAIL zw_req k=%0d got ren=%b addr=%h want 1/%h", k, o_imem_ren, o_imem_raddr, 4 * k); else n_pass++;
      tick();
      n_total++; if (o_valid !== 1'b1 || o_inst_pc !== 32'(4 * k) || o_inst !== 32'hA000_0000 + k || o_fetch_cnt !== 32'(k + 1))
        $display("FAIL zw_cap k=%0d got v=%b pc=%h inst=%h cnt=%0d want v=1 pc=%h cnt=%0d",
                 k, o_valid, o_inst_pc, o_inst, o_fetch_cnt, 4 * k, k + 1); else n_pass++;
    end
  endtask

  task automatic test_delayed();
    do_reset();
    drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1111_0000);
    tick();
    for (int k = 0; k < 3; k++) begin
      drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'hDEAD_BEEF);
      n_total++; if (o_imem_ren !== 1'b1 || o_imem_raddr !== 32'h4)
        $display("FAIL dly_hold k=%0d got ren=%b addr=%h want 1/4", k, o_imem_ren, o_imem_raddr); else n_pass++;
      tick();
      n_total++; if (o_valid !== 1'b0) $display("FAIL dly_valid k=%0d got %b want 0", k, o_valid); else n_pass++;
    end
    drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h2222_0004);
    tick();
    n_total++; if (o_valid !== 1'b1 || o_inst_pc !== 32'h4 || o_inst !== 32'h2222_0004 || o_fetch_cnt !== 32'd2)
      $display("FAIL dly_cap got v=%b pc=%h inst=%h cnt=%0d want 1/4/22220004/2", o_valid, o_inst_pc, o_inst, o_fetch_cnt); else n_pass++;
  endtask

  task automatic test_stall();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3300_0000 + k);
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      drv(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hBAD0_0000);
      n_total++; if (o_imem_ren !== 1'b0) $display("FAIL stall_ren k=%0d got %b want 0", k, o_imem_ren); else n_pass++;
      tick();
      n_total++; if (o_valid !== 1'b1 || o_inst_pc !== 32'h8 || o_inst !== 32'h3300_0002 || o_fetch_cnt !== 32'd3 || o_nxt_pc !== 32'hC)
        $display("FAIL stall_hold k=%0d got v=%b pc=%h inst=%h cnt=%0d nxt=%h", k, o_valid, o_inst_pc, o_inst, o_fetch_cnt, o_nxt_pc); else n_pass++;
    end
    drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3300_000C);
    n_total++; if (o_imem_ren !== 1'b1 || o_imem_raddr !== 32'hC)
      $display("FAIL stall_resume got ren=%b addr=%h want 1/c", o_imem_ren, o_imem_raddr); else n_pass++;
    tick();
    n_total++; if (o_inst_pc !== 32'hC || o_fetch_cnt !== 32'd4)
      $display("FAIL stall_cap got pc=%h cnt=%0d want c/4", o_inst_pc, o_fetch_cnt); else n_pass++;
  endtask

  task automatic test_redirect();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4400_0000 + k);
      tick();
    end
    drv(1'b0, 1'b1, 32'h100, 1'b0, 1'b1, 32'hBAD0_0010);
    n_total++; if (o_imem_ren !== 1'b0) $display("FAIL redir_ren got %b want 0", o_imem_ren); else n_pass++;
    tick();
    n_total++; if (o_valid !== 1'b0 || o_nxt_pc !== 32'h100 || o_fetch_cnt !== 32'd4)
      $display("FAIL redir_drop got v=%b nxt=%h cnt=%0d want 0/100/4", o_valid, o_nxt_pc, o_fetch_cnt); else n_pass++;
    drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h5500_0100);
    tick();
    n_total++; if (o_valid !== 1'b1 || o_inst_pc !== 32'h100 || o_inst !== 32'h5500_0100 || o_fetch_cnt !== 32'd5)
      $display("FAIL redir_cap got v=%b pc=%h inst=%h cnt=%0d want 1/100/55000100/5", o_valid, o_inst_pc, o_inst, o_fetch_cnt); else n_pass++;
    drv(1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
    tick();
    n_total++; if (o_valid !== 1'b0 || o_nxt_pc !== 32'h200)
      $display("FAIL redir_over_stall got v=%b nxt=%h want 0/200", o_valid, o_nxt_pc); else n_pass++;
  endtask

  task automatic test_misaligned_halt();
    logic [31:0] cnt_frozen;
    drv(1'b0, 1'b1, 32'h102, 1'b0, 1'b0, 32'h0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hBAD0_0102);
      n_total++; if (o_imem_ren !== 1'b0 || o_nxt_pc !== 32'h102)
        $display("FAIL mis_ren k=%0d got ren=%b nxt=%h want 0/102", k, o_imem_ren, o_nxt_pc); else n_pass++;
      tick();
      n_total++; if (o_valid !== 1'b0) $display("FAIL mis_valid k=%0d got %b want 0", k, o_valid); else n_pass++;
    end
    cnt_frozen = 32'd5;
    drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
    tick();
    for (int k = 0; k < 5; k++) begin
      drv(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'h0000_0040,
          1'b0, 1'($urandom_range(0, 1)), $urandom);
      n_total++; if (o_imem_ren !== 1'b0) $display("FAIL halt_ren k=%0d got %b want 0", k, o_imem_ren); else n_pass++;
      tick();
      n_total++; if (o_valid !== 1'b0 || o_nxt_pc !== 32'h102 || o_fetch_cnt !== cnt_frozen)
        $display("FAIL halt_hold k=%0d got v=%b nxt=%h cnt=%0d want 0/102/%0d", k, o_valid, o_nxt_pc, o_fetch_cnt, cnt_frozen); else n_pass++;
    end
    drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h6600_0000);
    #2 i_rst = 1'b1;
    #1;
    n_total++; if (o_nxt_pc !== 32'h0 || o_fetch_cnt !== 32'h0 || o_inst !== 32'h13 || o_valid !== 1'b0 || o_inst_pc !== 32'h0)
      $display("FAIL async_rst got nxt=%h cnt=%0d inst=%h v=%b ipc=%h", o_nxt_pc, o_fetch_cnt, o_inst, o_valid, o_inst_pc); else n_pass++;
    #2 i_rst = 1'b0;
    tick();
    n_total++; if (o_valid !== 1'b1 || o_inst_pc !== 32'h0 || o_fetch_cnt !== 32'd1)
      $display("FAIL rst_restart got v=%b pc=%h cnt=%0d want 1/0/1", o_valid, o_inst_pc, o_fetch_cnt); else n_pass++;
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_inst = 32'h13; m_inst_pc = 32'h0; m_cnt = 32'h0;
    m_valid = 1'b0; m_halted = 1'b0;
  endtask

  task automatic test_random();
    logic        st, rd, hl, rv;
    logic [31:0] rpc, dat;
    do_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      if (m_halted && $urandom_range(0, 9) == 0) begin
        do_reset();
        model_reset();
      end
      st  = ($urandom_range(0, 2) == 0);
      rd  = ($urandom_range(0, 9) == 0);
      hl  = ($urandom_range(0, 119) == 0);
      rv  = ($urandom_range(0, 1) == 1);
      dat = $urandom;
      case ($urandom_range(0, 7))
        0: rpc = 32'hFFFF_FFFC;
        1: rpc = 32'hFFFF_FFF8;
        2: rpc = {$urandom} | 32'h1;
        default: rpc = {$urandom} & 32'hFFFF_FFFC;
      endcase
      drv(st, rd, rpc, hl, rv, dat);
      m_ren = !m_halted && (m_pc % 4 == 0) && !(m_valid && st) && !rd && !hl;
      n_total++; if (o_imem_ren !== m_ren || o_imem_raddr !== m_pc)
        $display("FAIL rnd_req c=%0d got ren=%b addr=%h want %b/%h", c, o_imem_ren, o_imem_raddr, m_ren, m_pc); else n_pass++;
      if (!m_halted) begin
        if (hl) begin
          m_halted = 1'b1; m_valid = 1'b0;
        end else if (rd) begin
          m_pc = rpc; m_valid = 1'b0;
        end else if (m_valid && st) begin
          m_valid = 1'b1;
        end else if (m_ren && rv) begin
          m_inst = dat; m_inst_pc = m_pc; m_valid = 1'b1;
          m_pc = m_pc + 32'd4; m_cnt = m_cnt + 32'd1;
        end else begin
          m_valid = 1'b0;
        end
      end
      tick();
      n_total++; if (o_valid !== m_valid || o_inst !== m_inst || o_inst_pc !== m_inst_pc || o_nxt_pc !== m_pc || o_fetch_cnt !== m_cnt)
        $display("FAIL rnd_state c=%0d got v=%b inst=%h ipc=%h nxt=%h cnt=%0d want v=%b inst=%h ipc=%h nxt=%h cnt=%0d",
                 c, o_valid, o_inst, o_inst_pc, o_nxt_pc, o_fetch_cnt, m_valid, m_inst, m_inst_pc, m_pc, m_cnt); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_delayed();
    test_stall();
    test_redirect();
    test_misaligned_halt();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
